dip_switch_bank: RTL and testbench

- Multi-bank DIP-switch register file for arcade cores. Host-side config writes land in per-bank staging registers and are committed to the live switch outputs either immediately or at the next vblank rising edge.
- Flags which bits changed on each commit.
- Optionally holds the game core in reset after a change to a reset-sensitive switch.
- Sits between the host config bridge and the core's packed dip_switch_t inputs. Generalises the fixed single 16-bit switch word to N banks of configurable width.

---
 rtl/dip_switch_bank.sv | 151 +++++++++++++++
 tb/tb_dip_switch_bank.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dip_switch_bank.sv
// dip_switch_bank: multi-bank DIP-switch register file for arcade cores.
// Host writes land in per-bank staging registers and are committed to the
// live switch outputs either on the cycle after the write or on the next
// vblank rising edge. Each commit reports which live bits changed, and a
// change on a reset-sensitive bit holds the game core in reset for a while.
//
// Ports:
//   clk, reset       system clock, synchronous active-high reset
//   cfg_valid/ready  host write handshake (ready drops while core is in reset)
//   cfg_addr/data    bank index and write data (low BANK_WIDTH bits used)
//   cfg_err          one-cycle pulse after a write to a nonexistent bank
//   rd_addr/rd_live  read bank index, live (1) or staged (0) select
//   rd_data          registered read data, zero-extended, 1-cycle latency
//   vblank           vertical blank level, synchronous to clk
//   dip_out          live switch values with INVERT_MASK applied
//   pending          per-bank staged-but-not-committed flags
//   changed          one-cycle pulse when a commit altered live bits
//   changed_mask     old live ^ new live while changed=1, else 0
//   core_reset_req   core reset hold, RESET_CYCLES long
module dip_switch_bank #(
  parameter int unsigned                       NUM_BANKS     = 2,
  parameter int unsigned                       BANK_WIDTH    = 16,
  parameter logic [NUM_BANKS*BANK_WIDTH-1:0]   DEFAULT_VALUE = {NUM_BANKS{16'h9CF7}},
  parameter logic [NUM_BANKS*BANK_WIDTH-1:0]   INVERT_MASK   = '0,
  parameter logic [NUM_BANKS*BANK_WIDTH-1:0]   RESET_MASK    = '0,
  parameter bit                                COMMIT_MODE   = 1'b1,
  parameter int unsigned                       RESET_CYCLES  = 256
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              cfg_valid,
  output logic                              cfg_ready,
  input  logic [3:0]                        cfg_addr,
  input  logic [31:0]                       cfg_data,
  output logic                              cfg_err,
  input  logic [3:0]                        rd_addr,
  input  logic                              rd_live,
  output logic [31:0]                       rd_data,
  input  logic                              vblank,
  output logic [NUM_BANKS*BANK_WIDTH-1:0]   dip_out,
  output logic [NUM_BANKS-1:0]              pending,
  output logic                              changed,
  output logic [NUM_BANKS*BANK_WIDTH-1:0]   changed_mask,
  output logic                              core_reset_req
);

  localparam int unsigned TOTAL_W = NUM_BANKS * BANK_WIDTH;
  localparam int unsigned CNT_W   = $clog2(RESET_CYCLES + 1);

  // State registers
  logic [TOTAL_W-1:0]   staged_q, live_q, dip_q, chg_mask_q;
  logic [NUM_BANKS-1:0] pending_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 vblank_q, cfg_ready_q, cfg_err_q, changed_q, req_q;
  logic [31:0]          rd_q;

  // Next-state signals
  logic [TOTAL_W-1:0]   staged_d, live_d, diff;
  logic [NUM_BANKS-1:0] pending_d;
  logic [CNT_W-1:0]     cnt_d;
  logic [31:0]          rd_d;
  logic                 commit, wr_fire, addr_ok, rst_trig;

  // Upper cfg_data bits are ignored when BANK_WIDTH < 32
  logic unused_cfg_bits;
  assign unused_cfg_bits = ^cfg_data;

  // Next-state computation: commit first (uses pre-write staged), then write
  always_comb begin
    staged_d  = staged_q;
    live_d    = live_q;
    pending_d = pending_q;
    cnt_d     = cnt_q;
    rd_d      = '0;
    commit    = COMMIT_MODE ? (vblank & ~vblank_q) : (|pending_q);
    wr_fire   = cfg_valid & cfg_ready_q;
    addr_ok   = ({1'b0, cfg_addr} < 5'(NUM_BANKS));

    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      if (commit && pending_q[b]) begin
        live_d[b*BANK_WIDTH +: BANK_WIDTH] = staged_q[b*BANK_WIDTH +: BANK_WIDTH];
        pending_d[b] = 1'b0;
      end
    end

    // A same-cycle write re-arms pending after the commit cleared it
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      if (wr_fire && cfg_addr == 4'(b)) begin
        staged_d[b*BANK_WIDTH +: BANK_WIDTH] = cfg_data[BANK_WIDTH-1:0];
        pending_d[b] = 1'b1;
      end
    end

    diff     = live_q ^ live_d;
    rst_trig = |(diff & RESET_MASK);

    if (rst_trig) begin
      cnt_d = CNT_W'(RESET_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end

    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      if (rd_addr == 4'(b)) begin
        rd_d = rd_live ? 32'(live_q[b*BANK_WIDTH +: BANK_WIDTH])
                       : 32'(staged_q[b*BANK_WIDTH +: BANK_WIDTH]);
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      staged_q    <= DEFAULT_VALUE;
      live_q      <= DEFAULT_VALUE;
      dip_q       <= DEFAULT_VALUE ^ INVERT_MASK;
      pending_q   <= '0;
      chg_mask_q  <= '0;
      changed_q   <= 1'b0;
      cnt_q       <= '0;
      req_q       <= 1'b0;
      cfg_ready_q <= 1'b1;
      cfg_err_q   <= 1'b0;
      vblank_q    <= 1'b0;
      rd_q        <= '0;
    end else begin
      staged_q    <= staged_d;
      live_q      <= live_d;
      dip_q       <= live_d ^ INVERT_MASK;
      pending_q   <= pending_d;
      chg_mask_q  <= diff;
      changed_q   <= |diff;
      cnt_q       <= cnt_d;
      req_q       <= (cnt_d != '0);
      cfg_ready_q <= (cnt_d == '0);
      cfg_err_q   <= wr_fire & ~addr_ok;
      vblank_q    <= vblank;
      rd_q        <= rd_d;
    end
  end

  assign cfg_ready      = cfg_ready_q;
  assign cfg_err        = cfg_err_q;
  assign rd_data        = rd_q;
  assign dip_out        = dip_q;
  assign pending        = pending_q;
  assign changed        = changed_q;
  assign changed_mask   = chg_mask_q;
  assign core_reset_req = req_q;

endmodule

// File: tb/tb_dip_switch_bank.sv
// Testbench for dip_switch_bank. Three instances:
//   a: default parameters (vblank commit, no reset mask)
//   b: immediate commit, bit0 reset-sensitive, 4-cycle reset, upper bank inverted
//   c: vblank commit, bit0 reset-sensitive, 4-cycle reset
// Read results go through a scoreboard queue.
module tb_dip_switch_bank;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  // Instance a signals
  logic        a_cfg_valid, a_cfg_ready, a_cfg_err, a_rd_live, a_vblank;
  logic        a_changed, a_core_reset_req;
  logic [3:0]  a_cfg_addr, a_rd_addr;
  logic [31:0] a_cfg_data, a_rd_data, a_dip_out, a_changed_mask;
  logic [1:0]  a_pending;

  // Instance b signals
  logic        b_cfg_valid, b_cfg_ready, b_cfg_err, b_rd_live, b_vblank;
  logic        b_changed, b_core_reset_req;
  logic [3:0]  b_cfg_addr, b_rd_addr;
  logic [31:0] b_cfg_data, b_rd_data, b_dip_out, b_changed_mask;
  logic [1:0]  b_pending;

  // Instance c signals
  logic        c_cfg_valid, c_cfg_ready, c_cfg_err, c_rd_live, c_vblank;
  logic        c_changed, c_core_reset_req;
  logic [3:0]  c_cfg_addr, c_rd_addr;
  logic [31:0] c_cfg_data, c_rd_data, c_dip_out, c_changed_mask;
  logic [1:0]  c_pending;

  dip_switch_bank u_a (
    .clk(clk), .reset(reset),
    .cfg_valid(a_cfg_valid), .cfg_ready(a_cfg_ready), .cfg_addr(a_cfg_addr),
    .cfg_data(a_cfg_data), .cfg_err(a_cfg_err), .rd_addr(a_rd_addr),
    .rd_live(a_rd_live), .rd_data(a_rd_data), .vblank(a_vblank),
    .dip_out(a_dip_out), .pending(a_pending), .changed(a_changed),
    .changed_mask(a_changed_mask), .core_reset_req(a_core_reset_req)
  );

  dip_switch_bank #(
    .COMMIT_MODE(1'b0), .RESET_MASK(32'h0000_0001),
    .INVERT_MASK(32'hFFFF_0000), .RESET_CYCLES(4)
  ) u_b (
    .clk(clk), .reset(reset),
    .cfg_valid(b_cfg_valid), .cfg_ready(b_cfg_ready), .cfg_addr(b_cfg_addr),
    .cfg_data(b_cfg_data), .cfg_err(b_cfg_err), .rd_addr(b_rd_addr),
    .rd_live(b_rd_live), .rd_data(b_rd_data), .vblank(b_vblank),
    .dip_out(b_dip_out), .pending(b_pending), .changed(b_changed),
    .changed_mask(b_changed_mask), .core_reset_req(b_core_reset_req)
  );

  dip_switch_bank #(
    .COMMIT_MODE(1'b1), .RESET_MASK(32'h0000_0001), .RESET_CYCLES(4)
  ) u_c (
    .clk(clk), .reset(reset),
    .cfg_valid(c_cfg_valid), .cfg_ready(c_cfg_ready), .cfg_addr(c_cfg_addr),
    .cfg_data(c_cfg_data), .cfg_err(c_cfg_err), .rd_addr(c_rd_addr),
    .rd_live(c_rd_live), .rd_data(c_rd_data), .vblank(c_vblank),
    .dip_out(c_dip_out), .pending(c_pending), .changed(c_changed),
    .changed_mask(c_changed_mask), .core_reset_req(c_core_reset_req)
  );

  // Advance one clock; inputs change and outputs are sampled 1 time unit later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push expected read data when the address is driven, pop when rd_data is valid
  task automatic sb_read(input int inst, input logic [3:0] addr, input logic live,
                         input logic [31:0] exp, input string name);
    sb_t ent;
    logic [31:0] got;
    sb_q.push_back('{name, exp});
    if (inst == 0) begin a_rd_addr = addr; a_rd_live = live; end
    else           begin c_rd_addr = addr; c_rd_live = live; end
    tick();
    ent = sb_q.pop_front();
    got = (inst == 0) ? a_rd_data : c_rd_data;
    checks++;
    if (got !== ent.exp) begin
      errors++;
      $display("FAIL %s: rd_data got %h expected %h", ent.name, got, ent.exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++; if (a_dip_out !== 32'h9CF7_9CF7) begin errors++; $display("FAIL a_reset_dip: got %h expected %h", a_dip_out, 32'h9CF7_9CF7); end
    checks++; if (a_pending !== 2'b00) begin errors++; $display("FAIL a_reset_pending: got %b expected 00", a_pending); end
    checks++; if (a_cfg_ready !== 1'b1) begin errors++; $display("FAIL a_reset_ready: got %b expected 1", a_cfg_ready); end
    checks++; if (a_core_reset_req !== 1'b0) begin errors++; $display("FAIL a_reset_req: got %b expected 0", a_core_reset_req); end
    checks++; if ({a_changed, a_cfg_err, a_changed_mask} !== 34'h0) begin errors++; $display("FAIL a_reset_flags: got chg=%b err=%b mask=%h expected zeros", a_changed, a_cfg_err, a_changed_mask); end
    checks++; if (a_rd_data !== 32'h0) begin errors++; $display("FAIL a_reset_rd: got %h expected 0", a_rd_data); end
    checks++; if (b_dip_out !== 32'h6308_9CF7) begin errors++; $display("FAIL b_reset_dip: got %h expected %h", b_dip_out, 32'h6308_9CF7); end
    reset = 1'b0;
    tick();
    sb_read(0, 4'd1, 1'b1, 32'h0000_9CF7, "a_read_live1_after_reset");
  endtask

  task automatic test_vblank_commit();
    a_cfg_valid = 1'b1; a_cfg_addr = 4'd0; a_cfg_data = 32'h0000_1234;
    tick();
    a_cfg_valid = 1'b0;
    checks++; if (a_pending !== 2'b01) begin errors++; $display("FAIL a_staged_pending: got %b expected 01", a_pending); end
    checks++; if (a_dip_out !== 32'h9CF7_9CF7) begin errors++; $display("FAIL a_staged_dip: got %h expected %h", a_dip_out, 32'h9CF7_9CF7); end
    sb_read(0, 4'd0, 1'b0, 32'h0000_1234, "a_read_staged0");
    a_vblank = 1'b1;
    tick();
    checks++; if (a_dip_out !== 32'h9CF7_1234) begin errors++; $display("FAIL a_commit_dip: got %h expected %h", a_dip_out, 32'h9CF7_1234); end
    checks++; if (a_changed !== 1'b1) begin errors++; $display("FAIL a_commit_changed: got %b expected 1", a_changed); end
    checks++; if (a_changed_mask !== 32'h0000_8EC3) begin errors++; $display("FAIL a_commit_mask: got %h expected %h", a_changed_mask, 32'h0000_8EC3); end
    checks++; if (a_pending !== 2'b00) begin errors++; $display("FAIL a_commit_pending: got %b expected 00", a_pending); end
    tick();
    checks++; if ({a_changed, a_changed_mask} !== 33'h0) begin errors++; $display("FAIL a_changed_drop: got chg=%b mask=%h expected zeros", a_changed, a_changed_mask); end
    tick();
    checks++; if (a_changed !== 1'b0 || a_dip_out !== 32'h9CF7_1234) begin errors++; $display("FAIL a_vblank_held: got chg=%b dip=%h expected 0 %h", a_changed, a_dip_out, 32'h9CF7_1234); end
    a_vblank = 1'b0;
    sb_read(0, 4'd0, 1'b1, 32'h0000_1234, "a_read_live0");
  endtask

  task automatic test_back_to_back();
    a_cfg_valid = 1'b1; a_cfg_addr = 4'd1; a_cfg_data = 32'h0000_5555;
    tick();
    checks++; if (a_pending !== 2'b10) begin errors++; $display("FAIL a_b2b_pending_pre: got %b expected 10", a_pending); end
    a_cfg_data = 32'h0000_AAAA;
    a_vblank = 1'b1;
    tick();
    a_cfg_valid = 1'b0;
    checks++; if (a_dip_out !== 32'h5555_1234) begin errors++; $display("FAIL a_b2b_live: got %h expected %h", a_dip_out, 32'h5555_1234); end
    checks++; if (a_pending !== 2'b10) begin errors++; $display("FAIL a_b2b_pending_post: got %b expected 10", a_pending); end
    checks++; if (a_changed_mask !== 32'hC9A2_0000) begin errors++; $display("FAIL a_b2b_mask: got %h expected %h", a_changed_mask, 32'hC9A2_0000); end
    a_vblank = 1'b0;
    sb_read(0, 4'd1, 1'b0, 32'h0000_AAAA, "a_b2b_read_staged1");
    sb_read(0, 4'd1, 1'b1, 32'h0000_5555, "a_b2b_read_live1");
    a_vblank = 1'b1;
    tick();
    a_vblank = 1'b0;
    checks++; if (a_dip_out !== 32'hAAAA_1234 || a_pending !== 2'b00) begin errors++; $display("FAIL a_b2b_second_commit: got dip=%h pend=%b expected %h 00", a_dip_out, a_pending, 32'hAAAA_1234); end
  endtask

  task automatic test_bad_addr();
    a_cfg_valid = 1'b1; a_cfg_addr = 4'd7; a_cfg_data = 32'hFFFF_FFFF;
    tick();
    a_cfg_valid = 1'b0;
    checks++; if (a_cfg_err !== 1'b1) begin errors++; $display("FAIL a_err_pulse: got %b expected 1", a_cfg_err); end
    checks++; if (a_pending !== 2'b00 || a_dip_out !== 32'hAAAA_1234) begin errors++; $display("FAIL a_err_nochange: got pend=%b dip=%h expected 00 %h", a_pending, a_dip_out, 32'hAAAA_1234); end
    tick();
    checks++; if (a_cfg_err !== 1'b0) begin errors++; $display("FAIL a_err_drop: got %b expected 0", a_cfg_err); end
    sb_read(0, 4'd7, 1'b1, 32'h0, "a_read_bad_live");
    sb_read(0, 4'd7, 1'b0, 32'h0, "a_read_bad_staged");
    sb_read(0, 4'd0, 1'b0, 32'h0000_1234, "a_read_staged0_intact");
  endtask

  task automatic test_reset_req();
    int hi_req;
    int lo_rdy;
    bit seen_ready;
    b_cfg_valid = 1'b1; b_cfg_addr = 4'd0; b_cfg_data = 32'h0000_9CF6;
    tick();
    b_cfg_valid = 1'b0;
    checks++; if (b_pending !== 2'b01 || b_dip_out !== 32'h6308_9CF7) begin errors++; $display("FAIL b_write_stage: got pend=%b dip=%h expected 01 %h", b_pending, b_dip_out, 32'h6308_9CF7); end
    tick();
    checks++; if (b_dip_out !== 32'h6308_9CF6) begin errors++; $display("FAIL b_commit_dip: got %h expected %h", b_dip_out, 32'h6308_9CF6); end
    checks++; if (b_changed !== 1'b1 || b_changed_mask !== 32'h1) begin errors++; $display("FAIL b_commit_mask: got chg=%b mask=%h expected 1 00000001", b_changed, b_changed_mask); end
    checks++; if (b_core_reset_req !== 1'b1 || b_cfg_ready !== 1'b0) begin errors++; $display("FAIL b_req_start: got req=%b rdy=%b expected 1 0", b_core_reset_req, b_cfg_ready); end
    hi_req = 1; lo_rdy = 1; seen_ready = 1'b0;
    b_cfg_valid = 1'b1; b_cfg_addr = 4'd1; b_cfg_data = 32'h0000_1234;
    for (int i = 0; i < 10 && !seen_ready; i++) begin
      tick();
      if (b_core_reset_req) hi_req++;
      if (b_cfg_ready) seen_ready = 1'b1; else lo_rdy++;
    end
    checks++; if (hi_req != 4) begin errors++; $display("FAIL b_req_len: got %0d cycles expected 4", hi_req); end
    checks++; if (lo_rdy != 4) begin errors++; $display("FAIL b_ready_low_len: got %0d cycles expected 4", lo_rdy); end
    checks++; if (b_pending !== 2'b00) begin errors++; $display("FAIL b_stall_no_write: got %b expected 00", b_pending); end
    tick();
    b_cfg_valid = 1'b0;
    checks++; if (b_pending !== 2'b10) begin errors++; $display("FAIL b_held_accept: got %b expected 10", b_pending); end
    tick();
    checks++; if (b_dip_out !== 32'hEDCB_9CF6 || b_changed_mask !== 32'h8EC3_0000) begin errors++; $display("FAIL b_bank1_commit: got dip=%h mask=%h expected %h %h", b_dip_out, b_changed_mask, 32'hEDCB_9CF6, 32'h8EC3_0000); end
    checks++; if (b_core_reset_req !== 1'b0) begin errors++; $display("FAIL b_no_req_bank1: got %b expected 0", b_core_reset_req); end
    // Rewriting the live value still stages and commits, but changes nothing
    b_cfg_valid = 1'b1; b_cfg_addr = 4'd0; b_cfg_data = 32'h0000_9CF6;
    tick();
    b_cfg_valid = 1'b0;
    checks++; if (b_pending !== 2'b01) begin errors++; $display("FAIL b_same_pending: got %b expected 01", b_pending); end
    tick();
    checks++; if (b_pending !== 2'b00 || b_changed !== 1'b0 || b_core_reset_req !== 1'b0) begin errors++; $display("FAIL b_same_commit: got pend=%b chg=%b req=%b expected 00 0 0", b_pending, b_changed, b_core_reset_req); end
  endtask

  task automatic test_reset_abort();
    c_cfg_valid = 1'b1; c_cfg_addr = 4'd0; c_cfg_data = 32'h0000_9CF6;
    tick();
    c_cfg_addr = 4'd1; c_cfg_data = 32'h0000_1111;
    c_vblank = 1'b1;
    tick();
    c_cfg_valid = 1'b0;
    checks++; if (c_core_reset_req !== 1'b1 || c_pending !== 2'b10 || c_dip_out !== 32'h9CF7_9CF6) begin errors++; $display("FAIL c_pre_abort: got req=%b pend=%b dip=%h expected 1 10 %h", c_core_reset_req, c_pending, c_dip_out, 32'h9CF7_9CF6); end
    tick();
    reset = 1'b1;
    tick();
    checks++; if (c_core_reset_req !== 1'b0 || c_cfg_ready !== 1'b1) begin errors++; $display("FAIL c_abort_req: got req=%b rdy=%b expected 0 1", c_core_reset_req, c_cfg_ready); end
    checks++; if (c_pending !== 2'b00 || c_dip_out !== 32'h9CF7_9CF7) begin errors++; $display("FAIL c_abort_state: got pend=%b dip=%h expected 00 %h", c_pending, c_dip_out, 32'h9CF7_9CF7); end
    reset = 1'b0;
    c_vblank = 1'b0;
    sb_read(2, 4'd0, 1'b1, 32'h0000_9CF7, "c_read_live0");
    sb_read(2, 4'd1, 1'b0, 32'h0000_9CF7, "c_read_staged1");
  endtask

  initial begin
    reset = 1'b1;
    a_cfg_valid = 1'b0; a_cfg_addr = '0; a_cfg_data = '0; a_rd_addr = '0; a_rd_live = 1'b0; a_vblank = 1'b0;
    b_cfg_valid = 1'b0; b_cfg_addr = '0; b_cfg_data = '0; b_rd_addr = '0; b_rd_live = 1'b0; b_vblank = 1'b0;
    c_cfg_valid = 1'b0; c_cfg_addr = '0; c_cfg_data = '0; c_rd_addr = '0; c_rd_live = 1'b0; c_vblank = 1'b0;
    test_reset();
    test_vblank_commit();
    test_back_to_back();
    test_bad_addr();
    test_reset_req();
    test_reset_abort();
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("FAIL sb_drain: %0d entries left expected 0", sb_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
